// File: rtl/status_pkg.sv
// Condition-code definitions shared by the flag producer and the condition checker.
package status_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_ARITH   = 2'b01,
    OP_LOGIC   = 2'b10,
    OP_COMPARE = 2'b11
  } op_class_e;

  // Bit positions inside the packed {Z,C,N,V} flag nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // True when this instruction class/S-bit combination writes the flags
  function automatic logic sets_flags(input op_class_e op, input logic s_bit);
    return (op == OP_COMPARE) || (((op == OP_ARITH) || (op == OP_LOGIC)) && s_bit);
  endfunction

endpackage

// File: rtl/flag_gen.sv
// Combinational Z/C/N/V generation from execute-stage results.
module flag_gen
  import status_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  input  logic             shifter_carry,
  input  op_class_e        op_class,
  input  logic             old_v,
  output logic [3:0]       flags
);

  // Logic ops take carry from the shifter and leave V untouched; all else uses the adder
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    if (op_class == OP_LOGIC) begin
      flags[FLAG_C] = shifter_carry;
      flags[FLAG_V] = old_v;
    end else begin
      flags[FLAG_C] = carry;
      flags[FLAG_V] = overflow;
    end
  end

endmodule

// File: rtl/status_flag_unit.sv
// Architectural status register with a speculative pending stage and
// a bypassed effective view for back-to-back flag producers/consumers.
module status_flag_unit
  import status_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       op_class,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             shifter_carry,
  input  logic             msr_we,
  input  logic [3:0]       msr_data,
  output logic [3:0]       sr,
  output logic [3:0]       sr_eff,
  output logic             pending_valid
);

  logic [3:0] pending;
  logic [3:0] new_flags;
  logic       capture;
  op_class_e  op;

  assign op = op_class_e'(op_class);

  flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result        (alu_result),
    .carry         (alu_carry),
    .overflow      (alu_overflow),
    .shifter_carry (shifter_carry),
    .op_class      (op),
    .old_v         (sr_eff[FLAG_V]),
    .flags         (new_flags)
  );

  assign capture = valid && !stall && !flush && sets_flags(op, s_bit);

  // Bypass: a pending update is the newest architectural view
  assign sr_eff = pending_valid ? pending : sr;

  // Committed register: a direct write is younger than pending and overrides it, even under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (msr_we) begin
      sr <= msr_data;
    end else if (pending_valid && !stall) begin
      sr <= pending;
    end
  end

  // Pending stage: a fresh capture always wins; otherwise drain on commit or discard on msr
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (capture) begin
      pending       <= new_flags;
      pending_valid <= 1'b1;
    end else if (msr_we || (pending_valid && !stall)) begin
      pending_valid <= 1'b0;
    end
  end

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Producer side of the condition-code interface. Computes Z/C/N/V from execute-stage results and holds the architectural status register that the condition checker reads. Two registered stages: a pending (speculative) stage and a committed stage. A combinational effective view gives back-to-back flag-setting and conditional instructions correct flags without stalling.

## Interface
Parameters:
- WIDTH, 32, ALU result width in bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  execute-stage instruction present this cycle
- stall  in  1  pipeline hold; blocks both capture and commit
- flush  in  1  kill the instruction currently presented; does not affect pending or committed state
- op_class  in  2  00 NONE, 01 ARITH, 10 LOGIC, 11 COMPARE
- s_bit  in  1  flag-update request for ARITH/LOGIC
- alu_result  in  WIDTH  ALU result
- alu_carry  in  1  adder carry-out
- alu_overflow  in  1  adder signed overflow
- shifter_carry  in  1  barrel-shifter carry-out
- msr_we  in  1  direct flag write (move-to-status)
- msr_data  in  4  value for direct write, packed {Z,C,N,V}
- sr  out  4  committed flags, packed {Z,C,N,V}: sr[3]=Z, sr[2]=C, sr[1]=N, sr[0]=V
- sr_eff  out  4  effective flags (pending if valid, else committed), same packing; feeds condition checker
- pending_valid  out  1  a captured, uncommitted update exists

## Operation
- Flag generation:
  - N = alu_result[WIDTH-1].
  - Z = (alu_result == 0).
  - ARITH/COMPARE: C = alu_carry, V = alu_overflow.
  - LOGIC: C = shifter_carry, V = sr_eff[0] (unchanged).
- Capture condition: valid & ~stall & ~flush & (op_class==COMPARE | (op_class inside {ARITH,LOGIC} & s_bit)). COMPARE ignores s_bit. NONE never captures.
- On capture, the generated flags load the pending register and pending_valid←1.
- Commit: when pending_valid & ~stall, sr←pending. pending_valid←0 unless a capture happens on the same edge, in which case pending takes the new value and stays valid.
- msr_we is applied even when stall=1. It is younger than any pending update:
  - sr←msr_data; pending_valid←0 (discard older pending).
  - If a capture coincides with msr_we, the capture wins for pending. sr still ← msr_data.
- sr_eff = pending_valid ? pending : sr. This is purely combinational.
- flush has no effect on pending or sr. Older updates always commit.

## Timing
- Reset (rst=1 at an edge): sr=4'b0000, pending=4'b0000, pending_valid=0. Therefore sr_eff=4'b0000. rst overrides every other input.
- Capture at edge T → sr_eff reflects new flags after T. sr reflects them after edge T+1, if not stalled.
- Stall held N cycles with pending_valid=1: sr and pending frozen. Commit occurs on the first unstalled edge.
- Consecutive captures at T and T+1: pending holds the T+1 flags, sr holds the T flags after T+1. No update is lost.
- LOGIC V comes from sr_eff at capture time. A chain ARITH(S) then LOGIC(S) therefore keeps the ARITH V.
- Reset asserted mid-operation discards pending with no commit.

## Structure
- Shared package (status_pkg):
  - op_class enum (OP_NONE, OP_ARITH, OP_LOGIC, OP_COMPARE).
  - Bit-index constants FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
  - These are shared with the condition checker.
- Sub-module flag_gen: combinational, parameterised WIDTH. Inputs are alu_result, carries, overflow, op_class and old V; output is 4-bit packed flags.
- Top holds the pending/commit registers and the msr/capture priority logic.

## Test plan
- Reset, then ARITH s_bit=1, result=0, carry=1, ovf=0 → sr_eff=4'b1100 next cycle; sr=4'b1100 one cycle later.
- ARITH s_bit=1 with result=32'h8000_0000, ovf=1, then LOGIC s_bit=1 with result=1, shifter_carry=1 → sr_eff sequence 4'b0011, then 4'b0101 (V preserved).
- COMPARE with s_bit=0, result=0 → updates to Z=1. ARITH with s_bit=0 → no capture, pending_valid stays 0.
- Capture, then stall=1 for 3 cycles → sr unchanged and pending_valid=1 throughout; sr updates on the edge after stall drops.
- Capture at T, msr_we=1 with msr_data=4'b0010 at T+1 → sr=4'b0010, pending_valid=0, and the pending value is never committed. flush=1 during a capture → no state change.
- rst pulsed with pending_valid=1 and sr=4'b1111 → all outputs 0 on the next cycle.
